// File: rtl/ram_slave_ws.sv
// ram_slave_ws: wait-state RAM slave with req/ack handshake, byte enables and range check; ports clk, rst, addr, wdata, be, cs, cmd, rdata, slave_ack (+ slave_err when RAM_SLAVE_ERR_EN is defined)
module ram_slave_ws #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          DEPTH      = 10,
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 32,
  parameter int          RD_WAIT    = 2,
  parameter int          WR_WAIT    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic                    cs,
  input  logic                    cmd,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    slave_ack
`ifdef RAM_SLAVE_ERR_EN
  ,
  output logic                    slave_err
`endif
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LO = ADDR_WIDTH'(BASE_ADDR);
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  state_t st, st_d;
  logic [3:0] cnt, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, c_addr, off;
  logic [DATA_WIDTH-1:0] wdata_q, c_wdata;
  logic [NB-1:0] be_q, c_be;
  logic cmd_q, c_cmd, go_ack, in_rng;
  logic [IW-1:0] idx;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  // with zero wait states the access commits on the capture edge, so IDLE uses the live request
  always_comb begin
    c_addr  = st == IDLE ? addr : addr_q;
    c_wdata = st == IDLE ? wdata : wdata_q;
    c_be    = st == IDLE ? be : be_q;
    c_cmd   = st == IDLE ? cmd : cmd_q;
    off     = c_addr - LO;
    idx     = off[IW-1:0];
    in_rng  = off < ADDR_WIDTH'(DEPTH);
    st_d    = st;
    cnt_d   = cnt;
    case (st)
      IDLE: if (cs) begin
        cnt_d = cmd ? 4'(WR_WAIT) : 4'(RD_WAIT);
        st_d  = cnt_d == 4'd0 ? ACK : WAIT;
      end
      WAIT: begin
        cnt_d = cs ? cnt - 4'd1 : 4'd0;
        st_d  = !cs ? IDLE : cnt == 4'd1 ? ACK : WAIT;
      end
      default: st_d = IDLE;
    endcase
    go_ack = st_d == ACK && st != ACK;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      cmd_q   <= 1'b0;
      rdata   <= '0;
    end else begin
      st    <= st_d;
      cnt   <= cnt_d;
      rdata <= go_ack && !c_cmd && in_rng ? mem[idx] : '0;
      if (st == IDLE && cs) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        be_q    <= be;
        cmd_q   <= cmd;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && go_ack && c_cmd && in_rng)
      for (int i = 0; i < NB; i++)
        if (c_be[i]) mem[idx][8*i +: 8] <= c_wdata[8*i +: 8];
  end
  assign slave_ack = st == ACK;
`ifdef RAM_SLAVE_ERR_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else err_q <= go_ack && !in_rng;
  end
  assign slave_err = err_q;
`endif
endmodule

// File: tb/tb_ram_slave_ws.sv
// tb_ram_slave_ws: directed self-checking bench for ram_slave_ws (one instance RD_WAIT=2/WR_WAIT=1, one with zero waits)
module tb_ram_slave_ws;
  logic clk = 0, rst = 1;
  logic [31:0] addr = 0, wdata = 0, rdata, addr0 = 0, wdata0 = 0, rdata0;
  logic [3:0] be = 0, be0 = 0;
  logic cs = 0, cmd = 0, ack, cs0 = 0, cmd0 = 0, ack0;
  int tests = 0, errs = 0;
`ifdef RAM_SLAVE_ERR_EN
  logic err, err0;
`endif
  always #5 clk = ~clk;
  ram_slave_ws #(.RD_WAIT(2), .WR_WAIT(1)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .be(be), .cs(cs), .cmd(cmd),
    .rdata(rdata), .slave_ack(ack)
`ifdef RAM_SLAVE_ERR_EN
    , .slave_err(err)
`endif
  );
  ram_slave_ws #(.RD_WAIT(0), .WR_WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .addr(addr0), .wdata(wdata0), .be(be0), .cs(cs0), .cmd(cmd0),
    .rdata(rdata0), .slave_ack(ack0)
`ifdef RAM_SLAVE_ERR_EN
    , .slave_err(err0)
`endif
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input bit s, input logic q, input logic c, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    if (s) begin cs0 = q; cmd0 = c; addr0 = a; wdata0 = d; be0 = b; end
    else begin cs = q; cmd = c; addr = a; wdata = d; be = b; end
  endtask
  task automatic xfer(input string tag, input bit s, input logic c, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, input int lat, input logic [31:0] exp_rd, input bit exp_err);
    int k;
    logic pre;
    pre = 0;
    k = 99;
    drive(s, 1, c, a, d, b);
    for (int i = 1; i <= 20; i++) begin
      cyc();
      drive(s, 1, c, a ^ 32'h2, ~d, ~b);
      if (s ? ack0 : ack) begin k = i; break; end
      pre |= (s ? rdata0 : rdata) != 0;
    end
    check({tag, " latency"}, k, lat);
    check({tag, " rdata"}, s ? rdata0 : rdata, exp_rd);
    check({tag, " rdata before ack"}, {31'd0, pre}, 0);
`ifdef RAM_SLAVE_ERR_EN
    check({tag, " err"}, {31'd0, s ? err0 : err}, {31'd0, exp_err});
`else
    if (exp_err) tests += 0;
`endif
    drive(s, 0, 0, 0, 0, 0);
    cyc();
    check({tag, " after ack"}, {s ? ack0 : ack, (s ? rdata0 : rdata) != 0}, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    cyc(); cyc();
    rst = 0;
    check("reset ack", {31'd0, ack}, 0);
    check("reset rdata", rdata, 0);
    xfer("preload w3", 0, 1, 3, 32'h1234_5678, 4'hF, 2, 0, 0);
    rst = 1; cyc(); rst = 0;
    check("reset2 ack", {31'd0, ack}, 0);
    xfer("t1 read3", 0, 0, 3, 0, 4'hF, 3, 32'h1234_5678, 0);
    xfer("t2 w5 full", 0, 1, 5, 32'hDEAD_BEEF, 4'hF, 2, 0, 0);
    xfer("t2 w5 lane1", 0, 1, 5, 32'h0000_1200, 4'b0010, 2, 0, 0);
    xfer("t2 r5", 0, 0, 5, 0, 4'hF, 3, 32'hDEAD_12EF, 0);
    drive(0, 1, 1, 5, 0, 4'hF);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    cyc();
    check("t3 abort ack1", {31'd0, ack}, 0);
    cyc();
    check("t3 abort ack2", {31'd0, ack}, 0);
    xfer("t3 r5", 0, 0, 5, 0, 4'hF, 3, 32'hDEAD_12EF, 0);
    xfer("t4 w0", 1, 1, 0, 32'hA0A0_A0A0, 4'hF, 1, 0, 0);
    xfer("t4 w1", 1, 1, 1, 32'hB1B1_B1B1, 4'hF, 1, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    cyc();
    check("t4 ack a", {31'd0, ack0}, 1);
    check("t4 data a", rdata0, 32'hA0A0_A0A0);
    addr0 = 1;
    cyc();
    check("t4 gap", {31'd0, ack0}, 0);
    cyc();
    check("t4 ack b", {31'd0, ack0}, 1);
    check("t4 data b", rdata0, 32'hB1B1_B1B1);
    drive(1, 0, 0, 0, 0, 0);
    cyc();
    check("t4 idle", {31'd0, ack0}, 0);
    xfer("t5 r10 oor", 0, 0, 10, 0, 4'hF, 3, 0, 1);
    xfer("t5 w-1 oor", 0, 1, 32'hFFFF_FFFF, 32'h5555_5555, 4'hF, 2, 0, 1);
    xfer("t5 w21 oor", 0, 1, 21, 32'h0, 4'hF, 2, 0, 1);
    xfer("t5 w9 last", 0, 1, 9, 32'hCAFE_F00D, 4'hF, 2, 0, 0);
    xfer("t5 r9", 0, 0, 9, 0, 4'hF, 3, 32'hCAFE_F00D, 0);
    xfer("t5 r5", 0, 0, 5, 0, 4'hF, 3, 32'hDEAD_12EF, 0);
    xfer("t5 r3", 0, 0, 3, 0, 4'hF, 3, 32'h1234_5678, 0);
    xfer("be0 write", 0, 1, 3, 32'hFFFF_FFFF, 4'h0, 2, 0, 0);
    xfer("be0 r3", 0, 0, 3, 0, 4'hF, 3, 32'h1234_5678, 0);
    drive(0, 1, 1, 5, 0, 4'hF);
    cyc();
    rst = 1;
    cyc();
    rst = 0;
    drive(0, 0, 0, 0, 0, 0);
    check("t6 ack after rst", {31'd0, ack}, 0);
    cyc();
    check("t6 ack later", {31'd0, ack}, 0);
    xfer("t6 r5", 0, 0, 5, 0, 4'hF, 3, 32'hDEAD_12EF, 0);
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule

// File: doc/ram_slave_ws.md
Name: ram_slave_ws

Overview:
Parametrised wait-state RAM slave for the crossbar simulation environment. It extends the plain single-cycle RAM slave with:
- a registered request/acknowledge handshake
- independent, programmable read and write latencies
- byte-lane write enables
- address-range checking

It is used to model slow memories behind a crossbar slave port and to stress master stall and arbitration paths.

Parameters:
- BASE_ADDR, 32'h0000_0000, first word address decoded by this slave
- DEPTH, 10, number of DATA_WIDTH words in the array
- DATA_WIDTH, 32, data bus width; must be a multiple of 8
- ADDR_WIDTH, 32, address bus width (word addressing)
- RD_WAIT, 2, wait cycles inserted before a read ack; legal range 0..15
- WR_WAIT, 1, wait cycles inserted before a write ack; legal range 0..15

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- addr  input  ADDR_WIDTH  word address from master
- wdata  input  DATA_WIDTH  write data
- be  input  DATA_WIDTH/8  byte enables; bit i qualifies wdata[8i+7:8i]
- cs  input  1  request from master; held high until slave_ack is seen
- cmd  input  1  0 = read, 1 = write
- rdata  output  DATA_WIDTH  registered read data; valid only while slave_ack=1
- slave_ack  output  1  one-cycle completion pulse

Behaviour:
- Reset (rst=1 at a clock edge):
  - state goes to IDLE; slave_ack=0, rdata=0, wait counter=0, captured request cleared.
  - Memory contents are not reset.
  - Reset during WAIT aborts the transaction: no write is committed and no ack is issued.
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - If cs=1 at an edge, capture addr, wdata, be and cmd; load counter with N = cmd ? WR_WAIT : RD_WAIT.
  - Go to WAIT if N>0, else go to ACK.
- WAIT:
  - Each edge: if cs=0, abort to IDLE (no write, no ack). Otherwise decrement the counter; when it reaches 0, go to ACK.
  - addr/wdata/be/cmd changes during WAIT are ignored; the captured values are used.
- Entering ACK (same edge):
  - Write: for each byte lane with be[i]=1, mem[idx] lane i <= captured wdata lane i. Lanes with be[i]=0 are unchanged.
  - Read: rdata <= mem[idx].
- ACK:
  - slave_ack=1 for exactly one cycle; next state is IDLE unconditionally.
  - rdata returns to 0 on the following edge.
  - Write cycles present rdata=0.
- Latency: request first seen high in cycle T gives slave_ack high in cycle T+1+N.
  - Minimum request-to-request spacing is N+2 cycles, because IDLE must re-sample cs.
  - cs still high in the cycle after ACK starts a new transaction.
- Index: idx = addr - BASE_ADDR, truncated to clog2(DEPTH) bits.
  - The address is in range iff BASE_ADDR <= addr <= BASE_ADDR+DEPTH-1.
  - Out-of-range write: memory untouched; ack still given after WR_WAIT.
  - Out-of-range read: rdata=0; ack still given after RD_WAIT.
- Read-after-write: a read accepted in IDLE after a write's ACK returns the new data.
- be=0 on a write: a legal no-op write; ack is still given.

Optional Feature:
- Macro RAM_SLAVE_ERR_EN.
- Defined: adds output port slave_err (1 bit, reset 0).
  - slave_err is asserted together with slave_ack, for the same single cycle, when the captured address is out of range. It is 0 otherwise.
  - Memory and rdata behaviour are unchanged.
- Undefined: no slave_err port. Out-of-range accesses complete silently as described under Behaviour.

Test Plan:
1. Reset, then read addr=BASE_ADDR+3, RD_WAIT=2, cs held -> slave_ack high exactly 3 cycles after the request cycle; rdata = initial contents; slave_ack and rdata = 0 before and after.
2. Write 32'hDEADBEEF, be=4'b1111, to BASE_ADDR+5 (WR_WAIT=1), then write 32'h0000_1200 with be=4'b0010, then read the same address -> ack 2 cycles after each write request; read returns 32'hDEAD12EF.
3. Write with WR_WAIT=1, drop cs during the WAIT cycle, then read the same address -> no ack for the write; memory unchanged; the following read acks normally.
4. Hold cs=1 continuously with reads at BASE_ADDR, BASE_ADDR+1 (RD_WAIT=0) -> acks in alternate cycles (period 2); correct data on each ack.
5. Read BASE_ADDR+DEPTH and write BASE_ADDR-1 -> both acked with normal latency; rdata=0; no array word changes. With RAM_SLAVE_ERR_EN, slave_err pulses with each ack; an in-range access gives slave_err=0.
6. Assert rst in the WAIT cycle of a write -> next cycle slave_ack=0, state IDLE; the target word keeps its old value.
